// File: rtl/mem_arbiter_pkg.sv
// Shared memory-access types: access size (funct3[1:0]), arbiter state
// encoding and the NOP word returned on an aborted instruction fetch.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane handling for data accesses: store strobe/data replication,
// load lane select with sign/zero extension, and misalignment detect.
// Size encoding 3 is treated as a word access.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Lane selection of the read word by byte address
    always_comb begin
        rd_byte = '0;
        unique case (addr_lo)
            2'd0: rd_byte = rdata_in[7:0];
            2'd1: rd_byte = rdata_in[15:8];
            2'd2: rd_byte = rdata_in[23:16];
            2'd3: rd_byte = rdata_in[31:24];
            default: rd_byte = '0;
        endcase
        rd_half = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];
    end

    // Strobes, replicated store data, extended load data and alignment check
    always_comb begin
        strobe     = '0;
        wdata_out  = '0;
        rdata_out  = '0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                strobe    = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                strobe     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_out  = {2{wdata_in[15:0]}};
                rdata_out  = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
                misaligned = addr_lo[0];
            end
            default: begin
                strobe     = 4'b1111;
                wdata_out  = wdata_in;
                rdata_out  = rdata_in;
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one 32-bit memory bus between instruction fetch and data
// load/store. Data requests win; one access outstanding at a time.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort accesses that stay
// busy for TIMEOUT cycles (data -> d_err, fetch -> NOP instruction).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              bus_ren,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_strobe,
    input  logic              bus_busy,
    input  logic [31:0]       bus_rdata
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    arb_state_t state;

    logic       lat_store;
    mem_size_t  lat_size;
    logic       lat_uns;
    logic [1:0] lat_lo;
    logic       lat_err;

    mem_size_t   al_size;
    logic        al_uns;
    logic [1:0]  al_lo;
    logic [3:0]  al_strobe;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_mis;
    logic        abort;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Abort when the busy cycle being spent now would reach TIMEOUT
    always_comb begin
        abort = bus_busy && (tmo_cnt == TMO_LAST);
    end
`else
    // No timeout: accesses wait on bus_busy indefinitely
    always_comb begin
        abort = 1'b0;
    end
`endif

    // Aligner sees the live request in IDLE and the latched request during the access
    always_comb begin
        if (state == IDLE) begin
            al_size = mem_size_t'(d_size);
            al_uns  = d_unsigned;
            al_lo   = d_addr[1:0];
        end else begin
            al_size = lat_size;
            al_uns  = lat_uns;
            al_lo   = lat_lo;
        end
    end

    mem_lane_align u_align (
        .size        (al_size),
        .is_unsigned (al_uns),
        .addr_lo     (al_lo),
        .wdata_in    (d_wdata),
        .rdata_in    (bus_rdata),
        .strobe      (al_strobe),
        .wdata_out   (al_wdata),
        .rdata_out   (al_rdata),
        .misaligned  (al_mis)
    );

    // Arbitration FSM with registered bus and response outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            lat_store  <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_uns    <= 1'b0;
            lat_lo     <= '0;
            lat_err    <= 1'b0;
            bus_ren    <= 1'b0;
            bus_wen    <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_strobe <= '0;
            i_ready    <= 1'b0;
            i_rdata    <= '0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            d_err   <= 1'b0;
            case (state)
                IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    // Misaligned requests still pass through DACC, with strobes
                    // held low, so the error response keeps the two-cycle latency.
                    if (d_ren || d_wen) begin
                        state     <= DACC;
                        lat_store <= d_wen;
                        lat_size  <= mem_size_t'(d_size);
                        lat_uns   <= d_unsigned;
                        lat_lo    <= d_addr[1:0];
                        lat_err   <= al_mis;
                        if (!al_mis) begin
                            bus_ren    <= ~d_wen;
                            bus_wen    <= d_wen;
                            bus_addr   <= d_addr & WORD_MASK;
                            bus_wdata  <= d_wen ? al_wdata : '0;
                            bus_strobe <= al_strobe;
                        end
                    end else if (i_req) begin
                        state      <= IACC;
                        lat_err    <= 1'b0;
                        bus_ren    <= 1'b1;
                        bus_wen    <= 1'b0;
                        bus_addr   <= i_addr & WORD_MASK;
                        bus_wdata  <= '0;
                        bus_strobe <= 4'b1111;
                    end
                end
                DACC, IACC: begin
                    if (lat_err || !bus_busy || abort) begin
                        state      <= RESP;
                        bus_ren    <= 1'b0;
                        bus_wen    <= 1'b0;
                        bus_addr   <= '0;
                        bus_wdata  <= '0;
                        bus_strobe <= '0;
                        if (state == DACC) begin
                            d_ready <= 1'b1;
                            d_err   <= lat_err || abort;
                            d_rdata <= (lat_store || lat_err || abort) ? '0 : al_rdata;
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= abort ? NOP_INSN : bus_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand-written sequences
// for priority, bus stall, asynchronous reset and (optionally) timeout.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        nRst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_ren;
    logic        d_wen;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strobe;
    logic        bus_busy;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .d_ren      (d_ren),
        .d_wen      (d_wen),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .bus_ren    (bus_ren),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_strobe (bus_strobe),
        .bus_busy   (bus_busy),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        d_ren;
        logic        d_wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        i_req;
        logic [31:0] rdata;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strobe;
        logic        e_fetch;
        logic        e_err;
        logic        e_chk;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        d_ren = 1'b0;
        d_wen = 1'b0;
        i_req = 1'b0;
    endtask

    task automatic check_bus_idle(input string nm);
        chk({nm, " bus_ren"}, {31'd0, bus_ren}, 32'd0);
        chk({nm, " bus_wen"}, {31'd0, bus_wen}, 32'd0);
        chk({nm, " strobe"}, {28'd0, bus_strobe}, 32'd0);
    endtask

    // One complete transaction from a table entry; returns in an IDLE cycle
    task automatic apply_vec(input int k);
        vec_t v;
        string nm;
        v = vecs[k];
        nm = $sformatf("v%0d", k);
        d_ren      = v.d_ren;
        d_wen      = v.d_wen;
        d_size     = v.size;
        d_unsigned = v.uns;
        d_addr     = v.addr;
        d_wdata    = v.wdata;
        i_req      = v.i_req;
        i_addr     = v.addr;
        bus_rdata  = v.rdata;
        bus_busy   = 1'b0;
        tick();
        chk({nm, " bus_ren"}, {31'd0, bus_ren}, {31'd0, v.e_ren});
        chk({nm, " bus_wen"}, {31'd0, bus_wen}, {31'd0, v.e_wen});
        chk({nm, " bus_addr"}, bus_addr, v.e_addr);
        chk({nm, " bus_wdata"}, bus_wdata, v.e_wdata);
        chk({nm, " strobe"}, {28'd0, bus_strobe}, {28'd0, v.e_strobe});
        chk({nm, " early ready"}, {30'd0, i_ready, d_ready}, 32'd0);
        tick();
        chk({nm, " i_ready"}, {31'd0, i_ready}, {31'd0, v.e_fetch});
        chk({nm, " d_ready"}, {31'd0, d_ready}, {31'd0, ~v.e_fetch});
        if (v.e_fetch) begin
            chk({nm, " i_rdata"}, i_rdata, v.e_rdata);
        end else begin
            chk({nm, " d_err"}, {31'd0, d_err}, {31'd0, v.e_err});
            if (v.e_chk) chk({nm, " d_rdata"}, d_rdata, v.e_rdata);
        end
        check_bus_idle({nm, " resp"});
        drop_reqs();
        tick();
        chk({nm, " after"}, {30'd0, i_ready, d_ready}, 32'd0);
    endtask

    initial begin
        //        dren dwen sz uns addr        wdata         ireq rdata          eren ewen eaddr      ewdata        estb  fet err chk erdata
        vecs[0]  = '{0, 0, 2, 0, 32'h10,  32'h0,        1, 32'h00500093, 1, 0, 32'h10,  32'h0,        4'hF, 1, 0, 1, 32'h00500093};
        vecs[1]  = '{0, 1, 0, 0, 32'h103, 32'hAB,       0, 32'h0,        0, 1, 32'h100, 32'hABABABAB, 4'h8, 0, 0, 0, 32'h0};
        vecs[2]  = '{1, 0, 0, 0, 32'h2,   32'h0,        0, 32'h00800000, 1, 0, 32'h0,   32'h0,        4'h4, 0, 0, 1, 32'hFFFFFF80};
        vecs[3]  = '{1, 0, 0, 1, 32'h2,   32'h0,        0, 32'h00800000, 1, 0, 32'h0,   32'h0,        4'h4, 0, 0, 1, 32'h00000080};
        vecs[4]  = '{1, 0, 1, 0, 32'h6,   32'h0,        0, 32'h80011234, 1, 0, 32'h4,   32'h0,        4'hC, 0, 0, 1, 32'hFFFF8001};
        vecs[5]  = '{1, 0, 1, 1, 32'h4,   32'h0,        0, 32'h8001F234, 1, 0, 32'h4,   32'h0,        4'h3, 0, 0, 1, 32'h0000F234};
        vecs[6]  = '{0, 1, 1, 0, 32'h22,  32'h1234BEEF, 0, 32'h0,        0, 1, 32'h20,  32'hBEEFBEEF, 4'hC, 0, 0, 0, 32'h0};
        vecs[7]  = '{0, 1, 2, 0, 32'h40,  32'hDEADBEEF, 0, 32'h0,        0, 1, 32'h40,  32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0};
        vecs[8]  = '{1, 0, 2, 0, 32'h44,  32'h0,        0, 32'hCAFEF00D, 1, 0, 32'h44,  32'h0,        4'hF, 0, 0, 1, 32'hCAFEF00D};
        vecs[9]  = '{1, 0, 2, 0, 32'h6,   32'h0,        0, 32'h12345678, 0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 0, 32'h0};
        vecs[10] = '{0, 1, 1, 0, 32'h21,  32'h5555,     0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 0, 32'h0};
        vecs[11] = '{1, 1, 0, 0, 32'h1,   32'h5A,       0, 32'h0,        0, 1, 32'h0,   32'h5A5A5A5A, 4'h2, 0, 0, 0, 32'h0};
        vecs[12] = '{1, 0, 0, 0, 32'h3,   32'h0,        0, 32'h7F000000, 1, 0, 32'h0,   32'h0,        4'h8, 0, 0, 1, 32'h0000007F};

        nRst = 1'b0;
        drop_reqs();
        d_size = 2'd0; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0; i_addr = '0;
        bus_busy = 1'b0; bus_rdata = '0;
        repeat (3) tick();
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst ready/err", {29'd0, i_ready, d_ready, d_err}, 32'd0);
        chk("rst rdata", i_rdata | d_rdata, 32'd0);
        check_bus_idle("rst");
        nRst = 1'b1;
        tick();
        chk("post rst ready", {30'd0, i_ready, d_ready}, 32'd0);

        for (int k = 0; k < NV; k++) apply_vec(k);

        // Data and fetch requested together: data first, fetch three cycles later
        d_ren = 1'b1; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h8;
        i_req = 1'b1; i_addr = 32'h20; bus_rdata = 32'h11112222;
        tick();
        chk("prio d bus_addr", bus_addr, 32'h8);
        chk("prio d bus_ren", {31'd0, bus_ren}, 32'd1);
        tick();
        chk("prio d_ready", {31'd0, d_ready}, 32'd1);
        chk("prio d_rdata", d_rdata, 32'h11112222);
        chk("prio i_ready early", {31'd0, i_ready}, 32'd0);
        d_ren = 1'b0;
        bus_rdata = 32'h0020A023;
        tick();
        chk("prio idle bus", {31'd0, bus_ren}, 32'd0);
        tick();
        chk("prio i bus_addr", bus_addr, 32'h20);
        chk("prio i strobe", {28'd0, bus_strobe}, 32'hF);
        tick();
        chk("prio i_ready", {31'd0, i_ready}, 32'd1);
        chk("prio i_rdata", i_rdata, 32'h0020A023);
        chk("prio d_ready late", {31'd0, d_ready}, 32'd0);
        i_req = 1'b0;
        tick();

        // Bus stall for three cycles: outputs hold, ready one cycle after busy falls
        d_wen = 1'b1; d_size = 2'd0; d_addr = 32'h81; d_wdata = 32'h000000C3;
        bus_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d strobe", c), {28'd0, bus_strobe}, 32'h2);
            chk($sformatf("stall%0d wdata", c), bus_wdata, 32'hC3C3C3C3);
            chk($sformatf("stall%0d addr", c), bus_addr, 32'h80);
            chk($sformatf("stall%0d ready", c), {31'd0, d_ready}, 32'd0);
        end
        tick();
        bus_busy = 1'b0;
        chk("stall last strobe", {28'd0, bus_strobe}, 32'h2);
        tick();
        chk("stall d_ready", {31'd0, d_ready}, 32'd1);
        chk("stall d_err", {31'd0, d_err}, 32'd0);
        d_wen = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Bus never releases: abort after TMO busy cycles
        d_ren = 1'b1; d_size = 2'd2; d_addr = 32'h90;
        bus_busy = 1'b1;
        for (int c = 0; c < TMO; c++) begin
            tick();
            chk($sformatf("tmo%0d ready", c), {31'd0, d_ready}, 32'd0);
        end
        tick();
        chk("tmo d_ready", {31'd0, d_ready}, 32'd1);
        chk("tmo d_err", {31'd0, d_err}, 32'd1);
        d_ren = 1'b0;
        bus_busy = 1'b0;
        tick();
`else
        // Without the timeout the access waits on busy indefinitely
        d_ren = 1'b1; d_size = 2'd2; d_addr = 32'h90; bus_rdata = 32'h5;
        bus_busy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("wait%0d ready", c), {31'd0, d_ready}, 32'd0);
        end
        bus_busy = 1'b0;
        tick();
        chk("wait d_ready", {31'd0, d_ready}, 32'd1);
        chk("wait d_err", {31'd0, d_err}, 32'd0);
        d_ren = 1'b0;
        tick();
`endif

        // Asynchronous reset in the middle of a stalled store
        d_wen = 1'b1; d_size = 2'd2; d_addr = 32'hA0; d_wdata = 32'h12345678;
        bus_busy = 1'b1;
        tick();
        chk("arst pre strobe", {28'd0, bus_strobe}, 32'hF);
        #2;
        nRst = 1'b0;
        #1;
        check_bus_idle("arst");
        drop_reqs();
        bus_busy = 1'b0;
        tick();
        nRst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("arst%0d ready", c), {30'd0, i_ready, d_ready}, 32'd0);
        end
        apply_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
